hilo_mult_unit: RTL and testbench

HILO_MULT_UNIT -- requirements
Module: hilo_mult_unit

---
 rtl/hilo_mult_unit.sv | 110 +++++++++++
 tb/tb_hilo_mult_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_mult_unit.sv
// HI/LO multiply unit: 32-iteration shift-add multiplier with a sign/accumulate fix-up,
// architectural HI/LO registers and direct move-to-HI/LO.
module hilo_mult_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [1:0]  r_op;
  logic        r_sign;
  logic [31:0] r_mcand;
  logic [63:0] r_prod;
  logic [63:0] r_acc;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;

  logic        w_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_sum;
  logic [63:0] w_prod_fix;
  logic [63:0] w_res;

  // op[0]=1 selects unsigned, op[1]=1 selects accumulate
  assign w_signed = ~op[0];
  assign w_a_mag  = (w_signed && a[31]) ? (~a + 32'd1) : a;
  assign w_b_mag  = (w_signed && b[31]) ? (~b + 32'd1) : b;

  // upper half of the product register gets the partial sum, then the whole
  // register shifts right; multiplier bits drain out of the low half
  assign w_sum = {1'b0, r_prod[63:32]}
               + {1'b0, (r_prod[0] ? r_mcand : 32'd0)};

  assign w_prod_fix = (~r_op[0] && r_sign) ? (~r_prod + 64'd1) : r_prod;
  assign w_res      = w_prod_fix + (r_op[1] ? r_acc : 64'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_op    <= 2'd0;
      r_sign  <= 1'b0;
      r_mcand <= 32'd0;
      r_prod  <= 64'd0;
      r_acc   <= 64'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_CALC;
            r_cnt   <= 5'd0;
            r_op    <= op;
            r_sign  <= w_signed & (a[31] ^ b[31]);
            r_mcand <= w_a_mag;
            r_prod  <= {32'd0, w_b_mag};
            r_acc   <= op[1] ? {r_hi, r_lo} : 64'd0;
            r_busy  <= 1'b1;
          end else begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        S_CALC: begin
          r_prod <= {w_sum, r_prod[31:1]};
          r_cnt  <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi    <= w_res[63:32];
          r_lo    <= w_res[31:0];
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed bench for hilo_mult_unit: hand-computed products, accumulate,
// moves, ignored requests and reset behaviour.
module tb_hilo_mult_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_err = 0;

  int bcyc;
  int dcnt;
  int didx;

  always #5 clk = ~clk;

  hilo_mult_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic move(input logic h, input logic l,
                      input logic [31:0] d);
    @(negedge clk);
    mthi = h;
    mtlo = l;
    wdata = d;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    wdata = 32'd0;
  endtask

  // inj >= 0: at that sample either pulse rst (irst=1) or pulse an
  // ignored start (op=00, 7*7) together with mtlo 0x1234
  task automatic run_op(input logic [1:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic mvlo,
                        input logic [31:0] wd,
                        input int inj,
                        input logic irst);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    mtlo = mvlo;
    wdata = wd;
    @(negedge clk);
    start = 1'b0;
    mtlo = 1'b0;
    a = 32'd0;
    b = 32'd0;
    op = 2'd0;
    bcyc = 0;
    dcnt = 0;
    didx = -1;
    for (int i = 0; i < 40; i++) begin
      if (busy) bcyc++;
      if (done) begin
        dcnt++;
        if (didx < 0) didx = i;
      end
      if (i == inj) begin
        if (irst) rst = 1'b1;
        else begin
          start = 1'b1;
          op = 2'b00;
          a = 32'd7;
          b = 32'd7;
          mtlo = 1'b1;
          wdata = 32'h1234;
        end
      end else if (i == inj + 1) begin
        rst = 1'b0;
        start = 1'b0;
        a = 32'd0;
        b = 32'd0;
        mtlo = 1'b0;
        wdata = 32'd0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    op = 2'd0;
    a = 32'd0;
    b = 32'd0;
    mthi = 1'b0;
    mtlo = 1'b0;
    wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;

    run_op(2'b00, 32'hFFFFFFFF, 32'h2, 1'b0, 32'd0, -1, 1'b0);
    chk("mult_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    chk("mult_busy", 64'(bcyc), 64'd33);
    chk("mult_done", 64'(dcnt), 64'd1);
    chk("mult_didx", 64'(didx), 64'd33);

    run_op(2'b01, 32'hFFFFFFFF, 32'h2, 1'b0, 32'd0, -1, 1'b0);
    chk("multu_res", {hi, lo}, 64'h00000001_FFFFFFFE);

    move(1'b1, 1'b0, 32'h0);
    move(1'b0, 1'b1, 32'h5);
    chk("move_sep", {hi, lo}, 64'h00000000_00000005);
    run_op(2'b10, 32'd3, 32'hFFFFFFFC, 1'b0, 32'd0, -1, 1'b0);
    chk("madd_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFF9);

    move(1'b1, 1'b1, 32'hFFFFFFFF);
    chk("move_both", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
    run_op(2'b11, 32'd1, 32'd1, 1'b0, 32'd0, -1, 1'b0);
    chk("maddu_wrap", {hi, lo}, 64'd0);

    run_op(2'b00, 32'h00010001, 32'h00010001, 1'b0, 32'd0, 10, 1'b0);
    chk("ign_res", {hi, lo}, 64'h00000001_00020001);
    chk("ign_done", 64'(dcnt), 64'd1);
    chk("ign_busy", 64'(bcyc), 64'd33);
    repeat (3) @(negedge clk);
    chk("ign_hold", {hi, lo}, 64'h00000001_00020001);

    run_op(2'b00, 32'h00000123, 32'h00000456, 1'b0, 32'd0, 10, 1'b1);
    chk("rstmid_hilo", {hi, lo}, 64'd0);
    chk("rstmid_done", 64'(dcnt), 64'd0);
    chk("rstmid_busy", 64'(bcyc), 64'd11);
    chk("rstmid_idle", 64'(busy), 64'd0);

    run_op(2'b00, 32'hFFFFFFFD, 32'hFFFFFFFB, 1'b0, 32'd0, -1, 1'b0);
    chk("negneg_res", {hi, lo}, 64'h00000000_0000000F);
    chk("negneg_done", 64'(dcnt), 64'd1);

    move(1'b1, 1'b1, 32'h0);
    move(1'b0, 1'b1, 32'd10);
    run_op(2'b11, 32'd2, 32'd3, 1'b1, 32'hDEAD, -1, 1'b0);
    chk("start_wins", {hi, lo}, 64'h00000000_00000010);

    run_op(2'b00, 32'h80000000, 32'h00000001, 1'b0, 32'd0, -1, 1'b0);
    chk("mult_min", {hi, lo}, 64'hFFFFFFFF_80000000);

    @(negedge clk);
    rst = 1'b1;
    mtlo = 1'b1;
    wdata = 32'hABCD;
    @(negedge clk);
    rst = 1'b0;
    mtlo = 1'b0;
    chk("rst_prio", {hi, lo}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
